pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core. Drives enable and flush of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Resolves, in priority order, data-memory wait, multi-cycle mul/div, control-flow redirect, load-use hazard and instruction-memory wait. Also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: arbitrates dmem wait, mul/div,
// redirect, load-use and imem wait into per-register enable/flush controls.
module pipeline_hazard_ctrl #(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       d_rs1,
   input  logic [4:0]       d_rs2,
   input  logic             d_uses_rs1,
   input  logic             d_uses_rs2,
   input  logic [4:0]       e_rd,
   input  logic             e_is_load,
   input  logic             e_reg_write,
   input  logic             e_redirect,
   input  logic             e_muldiv_start,
   input  logic             muldiv_done,
   input  logic             m_mem_req,
   input  logic             dmem_ready,
   input  logic             imem_ready,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             if_id_flush,
   output logic             id_ex_enable,
   output logic             id_ex_flush,
   output logic             ex_mem_enable,
   output logic             ex_mem_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, MULDIV, DMEM_WAIT, REFILL} state_t;

   localparam logic [2:0]       BUB_LOAD = 3'(REDIRECT_BUBBLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t     state, state_nxt;
   logic [2:0] bub_cnt, bub_nxt;
   logic       dmem_stall;
   logic       load_use;
   logic       redirect_acc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != '1))
         return v + CNT_ONE;
      return v;
   endfunction

   assign dmem_stall = m_mem_req && !dmem_ready;
   assign load_use   = e_is_load && e_reg_write && (e_rd != 5'd0) &&
                       ((d_uses_rs1 && (d_rs1 == e_rd)) || (d_uses_rs2 && (d_rs2 == e_rd)));

   // A flushed register always has its enable dropped, so no register sees both.
   always_comb begin
      pc_enable     = 1'b1;
      if_id_enable  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_enable  = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_enable = 1'b1;
      ex_mem_flush  = 1'b0;
      state_nxt     = state;
      bub_nxt       = bub_cnt;
      redirect_acc  = 1'b0;

      case (state)
         RUN: begin
            if (dmem_stall) begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
               state_nxt     = DMEM_WAIT;
            end else if (e_muldiv_start) begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
               ex_mem_flush  = 1'b1;
               state_nxt     = MULDIV;
            end else if (e_redirect) begin
               redirect_acc = 1'b1;
               if_id_enable = 1'b0;
               if_id_flush  = 1'b1;
               id_ex_enable = 1'b0;
               id_ex_flush  = 1'b1;
               if (REDIRECT_BUBBLES > 0) begin
                  bub_nxt   = BUB_LOAD;
                  state_nxt = REFILL;
               end
            end else if (load_use) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               id_ex_enable = 1'b0;
               id_ex_flush  = 1'b1;
            end else if (!imem_ready) begin
               pc_enable    = 1'b0;
               if_id_enable = 1'b0;
               if_id_flush  = 1'b1;
            end
         end
         MULDIV: begin
            // done is only accepted once memory has released the pipeline
            if (dmem_stall) begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
            end else if (muldiv_done) begin
               state_nxt = RUN;
            end else begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
               ex_mem_flush  = 1'b1;
            end
         end
         DMEM_WAIT: begin
            if (!dmem_ready) begin
               pc_enable     = 1'b0;
               if_id_enable  = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
            end else begin
               state_nxt = RUN;
            end
         end
         REFILL: begin
            if_id_enable = 1'b0;
            if_id_flush  = 1'b1;
            if (dmem_stall) begin
               pc_enable     = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
            end else if (e_muldiv_start) begin
               pc_enable     = 1'b0;
               id_ex_enable  = 1'b0;
               ex_mem_enable = 1'b0;
               ex_mem_flush  = 1'b1;
               state_nxt     = MULDIV;
            end else if (e_redirect) begin
               redirect_acc = 1'b1;
               id_ex_enable = 1'b0;
               id_ex_flush  = 1'b1;
               bub_nxt      = BUB_LOAD;
            end else begin
               pc_enable = imem_ready;
               if (imem_ready) begin
                  bub_nxt = bub_cnt - 3'd1;
                  if ((bub_cnt == 3'd1) || (bub_cnt == 3'd0))
                     state_nxt = RUN;
               end
            end
         end
         default: state_nxt = RUN;
      endcase

      if (reset) begin
         pc_enable     = 1'b0;
         if_id_enable  = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_enable  = 1'b0;
         id_ex_flush   = 1'b1;
         ex_mem_enable = 1'b0;
         ex_mem_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         bub_cnt     <= 3'd0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state       <= state_nxt;
         bub_cnt     <= bub_nxt;
         stall_count <= sat_inc(stall_count, !pc_enable);
         flush_count <= sat_inc(flush_count, redirect_acc);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with REDIRECT_BUBBLES=2 and 4-bit
// counters so that counter saturation is reachable in a short run.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs1, d_rs2, e_rd;
   logic       d_uses_rs1, d_uses_rs2;
   logic       e_is_load, e_reg_write, e_redirect, e_muldiv_start;
   logic       muldiv_done, m_mem_req, dmem_ready, imem_ready;
   logic       pc_enable, if_id_enable, if_id_flush;
   logic       id_ex_enable, id_ex_flush, ex_mem_enable, ex_mem_flush;
   logic [3:0] stall_count, flush_count;

   int tests = 0;
   int fails = 0;

   // {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl}
   localparam logic [6:0] V_RST    = 7'b0010101;
   localparam logic [6:0] V_RUN    = 7'b1101010;
   localparam logic [6:0] V_LU     = 7'b0000110;
   localparam logic [6:0] V_REDIR  = 7'b1010110;
   localparam logic [6:0] V_REFILL = 7'b1011010;
   localparam logic [6:0] V_MDF    = 7'b0000001;
   localparam logic [6:0] V_FREEZE = 7'b0000000;
   localparam logic [6:0] V_IMEM   = 7'b0011010;

   pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(4)) dut (
      .clk(clk), .reset(reset),
      .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
      .e_rd(e_rd), .e_is_load(e_is_load), .e_reg_write(e_reg_write),
      .e_redirect(e_redirect), .e_muldiv_start(e_muldiv_start),
      .muldiv_done(muldiv_done), .m_mem_req(m_mem_req),
      .dmem_ready(dmem_ready), .imem_ready(imem_ready),
      .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
      .id_ex_enable(id_ex_enable), .id_ex_flush(id_ex_flush),
      .ex_mem_enable(ex_mem_enable), .ex_mem_flush(ex_mem_flush),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic idle();
      d_rs1 = 5'd0; d_rs2 = 5'd0; d_uses_rs1 = 1'b0; d_uses_rs2 = 1'b0;
      e_rd = 5'd0; e_is_load = 1'b0; e_reg_write = 1'b0;
      e_redirect = 1'b0; e_muldiv_start = 1'b0; muldiv_done = 1'b0;
      m_mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
             ex_mem_enable, ex_mem_flush};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      #7;
      chk("reset_out", V_RST);
      chk_cnt("reset_stall", stall_count, 4'd0);
      chk_cnt("reset_flush", flush_count, 4'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      #4; chk("idle_run", V_RUN);
      step();

      // load x5 in EX, add x6,x5,x1 in ID
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5;
      d_rs1 = 5'd5; d_uses_rs1 = 1'b1; d_rs2 = 5'd1; d_uses_rs2 = 1'b1;
      #4; chk("load_use_rs1", V_LU);
      step();
      e_rd = 5'd0; d_rs1 = 5'd0;
      #4; chk("load_use_x0", V_RUN);
      step();
      idle();
      #4; chk("after_lu", V_RUN);
      chk_cnt("lu_stall_cnt", stall_count, 4'd1);
      step();

      // redirect followed by two refill bubbles
      e_redirect = 1'b1;
      #4; chk("redir_c0", V_REDIR);
      step();
      e_redirect = 1'b0;
      #4; chk("redir_c1", V_REFILL);
      step();
      #4; chk("redir_c2", V_REFILL);
      step();
      #4; chk("redir_c3_run", V_RUN);
      chk_cnt("redir_flush_cnt", flush_count, 4'd1);
      chk_cnt("redir_stall_cnt", stall_count, 4'd1);
      step();

      // mul/div: start cycle plus 7 waiting cycles frozen, done on the 9th
      e_muldiv_start = 1'b1;
      #4; chk("md_start", V_MDF);
      step();
      e_muldiv_start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #4; chk("md_wait", V_MDF);
         step();
      end
      muldiv_done = 1'b1;
      #4; chk("md_done", V_RUN);
      step();
      muldiv_done = 1'b0;
      #4; chk("md_after", V_RUN);
      chk_cnt("md_stall_cnt", stall_count, 4'd9);
      step();

      // dmem wait three cycles, hazards raised meanwhile
      m_mem_req = 1'b1; dmem_ready = 1'b0;
      #4; chk("dm_c0", V_FREEZE);
      step();
      e_redirect = 1'b1;
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5; d_uses_rs1 = 1'b1;
      #4; chk("dm_c1_hazards", V_FREEZE);
      step();
      #4; chk("dm_c2_hazards", V_FREEZE);
      step();
      idle(); m_mem_req = 1'b1; dmem_ready = 1'b1;
      #4; chk("dm_release", V_RUN);
      step();
      #4; chk("dm_same_cycle_ready", V_RUN);
      step();
      idle();
      #4; chk("dm_after", V_RUN);
      chk_cnt("dm_stall_cnt", stall_count, 4'd12);
      chk_cnt("dm_flush_cnt", flush_count, 4'd1);
      step();

      // redirect + load-use + imem not ready: redirect wins
      e_redirect = 1'b1; imem_ready = 1'b0;
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5; d_uses_rs1 = 1'b1;
      #4; chk("combo_redir", V_REDIR);
      step();
      idle();
      #4; chk("combo_refill1", V_REFILL);
      step();
      #4; chk("combo_refill2", V_REFILL);
      step();
      #4; chk("combo_run", V_RUN);
      chk_cnt("combo_flush_cnt", flush_count, 4'd2);
      chk_cnt("combo_stall_cnt", stall_count, 4'd12);
      step();

      imem_ready = 1'b0;
      #4; chk("imem_wait", V_IMEM);
      step();
      idle();
      e_is_load = 1'b1; e_reg_write = 1'b1; e_rd = 5'd7;
      d_rs1 = 5'd3; d_uses_rs1 = 1'b1; d_rs2 = 5'd7; d_uses_rs2 = 1'b1;
      #4; chk("load_use_rs2", V_LU);
      step();
      d_uses_rs2 = 1'b0;
      #4; chk("load_use_rs2_unused", V_RUN);
      step();
      idle();

      // muldiv outranks redirect
      e_muldiv_start = 1'b1; e_redirect = 1'b1;
      #4; chk("md_over_redir", V_MDF);
      step();
      idle(); muldiv_done = 1'b1;
      #4; chk("md_over_redir_done", V_RUN);
      step();
      idle();
      #4;
      chk_cnt("pri_stall_cnt", stall_count, 4'd15);
      chk_cnt("pri_flush_cnt", flush_count, 4'd2);
      step();

      // stall counter saturates at all-ones
      imem_ready = 1'b0;
      #4; chk("sat_imem1", V_IMEM);
      step();
      #4; chk("sat_imem2", V_IMEM);
      step();
      idle();
      #4; chk_cnt("sat_stall_cnt", stall_count, 4'd15);
      step();

      // reset in the middle of a mul/div freeze
      e_muldiv_start = 1'b1;
      #4; chk("rst_md_start", V_MDF);
      step();
      e_muldiv_start = 1'b0;
      #2; chk("rst_md_wait", V_MDF);
      reset = 1'b1;
      #1; chk("rst_mid_out", V_RST);
      chk_cnt("rst_mid_stall", stall_count, 4'd0);
      chk_cnt("rst_mid_flush", flush_count, 4'd0);
      step();
      reset = 1'b0;
      idle();
      #4; chk("rst_after_run", V_RUN);
      chk_cnt("rst_after_stall", stall_count, 4'd0);
      chk_cnt("rst_after_flush", flush_count, 4'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
